video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised, runtime-reprogrammable video timing generator for the HDMI output path. Produces HS/VS/DE/HB/VB, active-area pixel coordinates and frame/line start strobes from a single pixel clock, with counter width and output pipeline depth set by parameters. Timing values are double-buffered: a load request is held pending and applied only at the frame boundary, so mode changes never produce a torn frame. It drives the pixel fetch logic and the TMDS encoder in place of the fixed-latency sync generator.

## Interface
- CNT_W, 12, width of all timing inputs, counters and coordinate outputs (8..16)
- PIPE, 2, output latency in clocks from counter state to outputs (1..4)

- I_pxl_clk  in  1  pixel clock
- I_rst  in  1  synchronous reset, active-high
- I_en  in  1  run enable; low stalls counters and pipeline
- I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CNT_W each  horizontal timing (clocks)
- I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CNT_W each  vertical timing (lines)
- I_hs_pol, I_vs_pol  in  1 each  sync polarity, 1 = active-high
- I_cfg_load  in  1  one-cycle request to capture all timing/polarity inputs
- O_cfg_busy  out  1  load captured, not yet applied
- O_de, O_hs, O_vs, O_hb, O_vb  out  1 each  data enable, syncs, blanking
- O_x, O_y  out  CNT_W each  active-area coordinates, 0 outside active
- O_sof, O_sol  out  1 each  one-cycle start-of-frame / start-of-line strobes

## Operation
- Three register sets: pending (captured), active (used by counters), inputs.
- Reset (I_rst=1 at an edge): pending and active <= inputs; busy=0; H_cnt=V_cnt=0; all pipeline stages flushed to idle.
- I_cfg_load=1: pending <= inputs, busy=1. Repeated loads while busy overwrite pending; busy stays 1.
- Frame end = (H_cnt >= act_h_total-1) and (V_cnt >= act_v_total-1), with I_en=1. At frame end: if busy, active <= pending, busy <= 0. If I_cfg_load coincides with frame end, active <= inputs directly, busy <= 0.
- H_cnt: wraps to 0 when >= act_h_total-1, else +1. V_cnt: +1 on H wrap; wraps to 0 at frame end. >= comparisons guard against out-of-range counts.
- I_en=0: counters, config application and all pipeline stages hold; I_cfg_load still captures into pending.
- Decode (stage 0, from counters and active config), all sums in CNT_W+2 bits, no overflow:
  - hs_act = H_cnt < act_h_sync; vs_act = V_cnt < act_v_sync (sync=0 -> never active).
  - h_act = hs+hbp <= H_cnt < hs+hbp+hres; v_act likewise (res=0 -> never active).
  - de = h_act & v_act; hb = ~h_act; vb = ~v_act.
  - x = H_cnt-(hs+hbp) when de else 0; y = V_cnt-(vs+vbp) when de else 0.
  - sof = (H_cnt==0 & V_cnt==0); sol = (H_cnt==0).
  - O_hs = hs_act XNOR act_hs_pol... i.e. hs_act when pol=1, ~hs_act when pol=0; same for VS. Polarity travels with the pipeline.

## Timing
- Outputs after edge k+PIPE equal the stage-0 decode of the counter state held during cycle k (counting only I_en=1 cycles).
- First cycle after reset release holds counter (0,0); O_sof=1 PIPE cycles later.
- Reset values of all outputs: O_de=0, O_hb=1, O_vb=1, O_hs=~I_hs_pol, O_vs=~I_vs_pol (inactive level of reset-time polarity), O_x=O_y=0, O_sof=O_sol=0, O_cfg_busy=0.
- New config first affects counter (0,0) of the next frame; outputs change PIPE cycles after that.
- O_cfg_busy rises the cycle after I_cfg_load; falls the cycle after frame end.

## Test plan
- Config h_total=10,h_sync=2,h_bp=1,h_res=5,v_total=6,v_sync=1,v_bp=1,v_res=3, pol=1,1, PIPE=2 -> per line HS high 2 clks, DE at H_cnt 3..7 with O_x 0..4; 15 DE clocks/frame; O_y 0..2; frame period 60 clks; O_sof every 60.
- Same config, pol=0,0 -> HS/VS inverted, DE/x/y unchanged; reset values O_hs=O_vs=1.
- Mid-frame I_cfg_load with h_total=12,h_res=7 -> busy=1 until frame end; current frame keeps 10-clk lines; next frame 12-clk lines, 7 DE/line, busy=0.
- I_cfg_load on exact frame-end cycle -> applied immediately, busy never asserts; two loads mid-frame -> second values applied.
- I_en low for 5 cycles mid-line -> all outputs frozen 5 cycles, then sequence resumes without skipped or repeated pixels.
- I_rst asserted mid-frame for 1 cycle -> next cycle counters (0,0), outputs at reset values until O_sof appears PIPE cycles after release; h_sync=0 and v_res=0 -> HS never active, DE never asserts.

Source files
------------

// File: rtl/video_timing_if.sv
// Timing configuration inputs and video timing outputs of video_timing_gen.
interface video_timing_if #(parameter int CNT_W = 12);
  logic             I_en;
  logic [CNT_W-1:0] I_h_total, I_h_sync, I_h_bporch, I_h_res;
  logic [CNT_W-1:0] I_v_total, I_v_sync, I_v_bporch, I_v_res;
  logic             I_hs_pol, I_vs_pol, I_cfg_load;
  logic             O_cfg_busy, O_de, O_hs, O_vs, O_hb, O_vb;
  logic [CNT_W-1:0] O_x, O_y;
  logic             O_sof, O_sol;

  modport master (
    output I_en, I_h_total, I_h_sync, I_h_bporch, I_h_res,
           I_v_total, I_v_sync, I_v_bporch, I_v_res, I_hs_pol, I_vs_pol, I_cfg_load,
    input  O_cfg_busy, O_de, O_hs, O_vs, O_hb, O_vb, O_x, O_y, O_sof, O_sol
  );
  modport slave (
    input  I_en, I_h_total, I_h_sync, I_h_bporch, I_h_res,
           I_v_total, I_v_sync, I_v_bporch, I_v_res, I_hs_pol, I_vs_pol, I_cfg_load,
    output O_cfg_busy, O_de, O_hs, O_vs, O_hb, O_vb, O_x, O_y, O_sof, O_sol
  );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable video timing generator; config is double-buffered and
// swapped only at the frame boundary, outputs delayed by a PIPE-deep register chain.
module video_timing_gen #(
  parameter int CNT_W = 12,
  parameter int PIPE  = 2
) (
  input  logic           I_pxl_clk,
  input  logic           I_rst,
  video_timing_if.slave  bus
);
  localparam int W1 = CNT_W + 1;
  localparam int W2 = CNT_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0] h_total, h_sync, h_bp, h_res;
    logic [CNT_W-1:0] v_total, v_sync, v_bp, v_res;
    logic             hs_pol, vs_pol;
  } cfg_t;

  typedef struct packed {
    logic             de, hs, vs, hb, vb;
    logic [CNT_W-1:0] x, y;
    logic             sof, sol;
  } pix_t;

  cfg_t             cfg_in, pend, act;
  logic             busy;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap, frame_end;
  logic [W2-1:0]    hc, vc, h_beg, h_end, v_beg, v_end;
  logic             h_act, v_act;
  pix_t             dec, idle;
  pix_t             pipe_q [PIPE];

  assign cfg_in = {bus.I_h_total, bus.I_h_sync, bus.I_h_bporch, bus.I_h_res,
                   bus.I_v_total, bus.I_v_sync, bus.I_v_bporch, bus.I_v_res,
                   bus.I_hs_pol, bus.I_vs_pol};

  // Compared as cnt+1 >= total so a total of 0 behaves like 1 instead of underflowing.
  assign h_wrap    = (W1'(h_cnt) + W1'(1)) >= W1'(act.h_total);
  assign v_wrap    = (W1'(v_cnt) + W1'(1)) >= W1'(act.v_total);
  assign frame_end = h_wrap & v_wrap;

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      pend  <= cfg_in;
      act   <= cfg_in;
      busy  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (bus.I_cfg_load) begin
        pend <= cfg_in;
        busy <= 1'b1;
      end
      if (bus.I_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        // A load landing on the boundary bypasses pending and takes effect at once.
        if (frame_end) begin
          if (bus.I_cfg_load) begin
            act  <= cfg_in;
            busy <= 1'b0;
          end else if (busy) begin
            act  <= pend;
            busy <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    hc    = W2'(h_cnt);
    vc    = W2'(v_cnt);
    h_beg = W2'(act.h_sync) + W2'(act.h_bp);
    h_end = h_beg + W2'(act.h_res);
    v_beg = W2'(act.v_sync) + W2'(act.v_bp);
    v_end = v_beg + W2'(act.v_res);
    h_act = (hc >= h_beg) && (hc < h_end);
    v_act = (vc >= v_beg) && (vc < v_end);
    dec     = '0;
    dec.de  = h_act & v_act;
    dec.hb  = ~h_act;
    dec.vb  = ~v_act;
    dec.hs  = ~((hc < W2'(act.h_sync)) ^ act.hs_pol);
    dec.vs  = ~((vc < W2'(act.v_sync)) ^ act.vs_pol);
    dec.x   = (h_act & v_act) ? CNT_W'(hc - h_beg) : '0;
    dec.y   = (h_act & v_act) ? CNT_W'(vc - v_beg) : '0;
    dec.sof = (h_cnt == '0) && (v_cnt == '0);
    dec.sol = (h_cnt == '0);
  end

  always_comb begin
    idle    = '0;
    idle.hb = 1'b1;
    idle.vb = 1'b1;
    idle.hs = ~bus.I_hs_pol;
    idle.vs = ~bus.I_vs_pol;
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= idle;
    end else if (bus.I_en) begin
      pipe_q[0] <= dec;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.O_cfg_busy = busy;
  assign bus.O_de  = pipe_q[PIPE-1].de;
  assign bus.O_hs  = pipe_q[PIPE-1].hs;
  assign bus.O_vs  = pipe_q[PIPE-1].vs;
  assign bus.O_hb  = pipe_q[PIPE-1].hb;
  assign bus.O_vb  = pipe_q[PIPE-1].vb;
  assign bus.O_x   = pipe_q[PIPE-1].x;
  assign bus.O_y   = pipe_q[PIPE-1].y;
  assign bus.O_sof = pipe_q[PIPE-1].sof;
  assign bus.O_sol = pipe_q[PIPE-1].sol;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position reference model checked every cycle,
// a table of per-frame measurements, and directed reload/stall/reset sequences.
module tb_video_timing_gen;
  localparam int CNT_W = 12;
  localparam int PIPE  = 2;
  localparam int VW    = 8 + 2*CNT_W;

  typedef struct {
    int ht, hs, hbp, hres, vt, vs, vbp, vres;
    bit hp, vp;
  } tcfg_t;

  typedef struct {
    bit de, hs, vs, hb, vb, sof, sol;
    int x, y;
  } exp_t;

  typedef struct {
    tcfg_t c;
    int period, de_n, hs_n, vs_n, mx, my;
  } rec_t;

  bit clk = 1'b0;
  bit rst = 1'b0;
  always #5 clk = ~clk;

  video_timing_if #(.CNT_W(CNT_W)) bus();

  video_timing_gen #(.CNT_W(CNT_W), .PIPE(PIPE)) dut (
    .I_pxl_clk(clk),
    .I_rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  tcfg_t m_act, m_pend;
  bit    m_busy;
  bit    m_ready = 1'b0;
  int    m_pos;
  exp_t  q[$];

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic tcfg_t mk(int ht, int hs, int hbp, int hres, int vt, int vs, int vbp, int vres,
                               bit hp, bit vp);
    tcfg_t c;
    c.ht = ht; c.hs = hs; c.hbp = hbp; c.hres = hres;
    c.vt = vt; c.vs = vs; c.vbp = vbp; c.vres = vres;
    c.hp = hp; c.vp = vp;
    return c;
  endfunction

  task automatic set_cfg(tcfg_t c);
    bus.I_h_total = CNT_W'(c.ht); bus.I_h_sync = CNT_W'(c.hs);
    bus.I_h_bporch = CNT_W'(c.hbp); bus.I_h_res = CNT_W'(c.hres);
    bus.I_v_total = CNT_W'(c.vt); bus.I_v_sync = CNT_W'(c.vs);
    bus.I_v_bporch = CNT_W'(c.vbp); bus.I_v_res = CNT_W'(c.vres);
    bus.I_hs_pol = c.hp; bus.I_vs_pol = c.vp;
  endtask

  function automatic tcfg_t get_in();
    return mk(int'(bus.I_h_total), int'(bus.I_h_sync), int'(bus.I_h_bporch), int'(bus.I_h_res),
              int'(bus.I_v_total), int'(bus.I_v_sync), int'(bus.I_v_bporch), int'(bus.I_v_res),
              bus.I_hs_pol, bus.I_vs_pol);
  endfunction

  function automatic tcfg_t rand_cfg();
    int ht, vt;
    ht = $urandom_range(20, 4);
    vt = $urandom_range(8, 2);
    return mk(ht, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(ht, 0),
              vt, $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(vt, 0),
              1'($urandom), 1'($urandom));
  endfunction

  // Pixel at column h, line v of a frame, straight from the timing rules.
  function automatic exp_t decode(int h, int v, tcfg_t c);
    exp_t d;
    bit ha, va;
    ha = (h >= c.hs + c.hbp) && (h < c.hs + c.hbp + c.hres);
    va = (v >= c.vs + c.vbp) && (v < c.vs + c.vbp + c.vres);
    d.de = ha && va;
    d.hb = !ha;
    d.vb = !va;
    d.hs = c.hp ? (h < c.hs) : !(h < c.hs);
    d.vs = c.vp ? (v < c.vs) : !(v < c.vs);
    d.x = d.de ? h - (c.hs + c.hbp) : 0;
    d.y = d.de ? v - (c.vs + c.vbp) : 0;
    d.sof = (h == 0) && (v == 0);
    d.sol = (h == 0);
    return d;
  endfunction

  function automatic exp_t idle_of(tcfg_t c);
    exp_t d;
    d.de = 0; d.hb = 1; d.vb = 1; d.hs = !c.hp; d.vs = !c.vp;
    d.sof = 0; d.sol = 0; d.x = 0; d.y = 0;
    return d;
  endfunction

  function automatic int max1(int a);
    return (a < 1) ? 1 : a;
  endfunction

  // Frame is tracked as a linear pixel index; the latency is a FIFO of decoded pixels.
  task automatic model_update();
    tcfg_t in;
    int ht, vt;
    in = get_in();
    if (rst) begin
      m_act = in; m_pend = in; m_busy = 0; m_pos = 0; m_ready = 1;
      q.delete();
      for (int i = 0; i < PIPE; i++) q.push_back(idle_of(in));
    end else if (m_ready) begin
      if (bus.I_cfg_load) begin m_pend = in; m_busy = 1; end
      if (bus.I_en) begin
        ht = max1(m_act.ht);
        vt = max1(m_act.vt);
        q.push_back(decode(m_pos % ht, m_pos / ht, m_act));
        void'(q.pop_front());
        if (m_pos >= ht*vt - 1) begin
          m_pos = 0;
          if (bus.I_cfg_load) begin m_act = in; m_busy = 0; end
          else if (m_busy) begin m_act = m_pend; m_busy = 0; end
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    exp_t e;
    e = q[0];
    return {m_busy, e.de, e.hs, e.vs, e.hb, e.vb, e.sof, e.sol, CNT_W'(e.x), CNT_W'(e.y)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.O_cfg_busy, bus.O_de, bus.O_hs, bus.O_vs, bus.O_hb, bus.O_vb,
            bus.O_sof, bus.O_sol, bus.O_x, bus.O_y};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (m_ready) chk("model", 64'(dut_vec()), 64'(exp_vec()));
  endtask

  task automatic do_reset(tcfg_t c);
    set_cfg(c);
    rst = 1; bus.I_en = 1; bus.I_cfg_load = 0;
    step();
    rst = 0;
  endtask

  // Measures one full frame starting at the next O_sof.
  task automatic measure(output int period, output int de_n, output int hs_n, output int vs_n,
                         output int mx, output int my);
    int guard;
    period = 0; de_n = 0; hs_n = 0; vs_n = 0; mx = 0; my = 0;
    guard = 0;
    while (bus.O_sof !== 1'b1 && guard < 4000) begin step(); guard++; end
    if (bus.O_sof !== 1'b1) begin
      chk("sof_timeout", 64'(guard), 64'(0));
    end else begin
      do begin
        if (bus.O_de) begin
          de_n++;
          if (int'(bus.O_x) > mx) mx = int'(bus.O_x);
          if (int'(bus.O_y) > my) my = int'(bus.O_y);
        end
        hs_n += int'(bus.O_hs);
        vs_n += int'(bus.O_vs);
        step();
        period++;
      end while (bus.O_sof !== 1'b1 && period < 4000);
    end
  endtask

  initial begin
    rec_t  tbl[5];
    tcfg_t c1, c12, c14;
    int    p, dn, hn, vn, mx, my, guard;
    bit    seen_busy;
    logic [VW-1:0] snap;

    c1  = mk(10, 2, 1, 5, 6, 1, 1, 3, 1, 1);
    c12 = mk(12, 2, 1, 7, 6, 1, 1, 3, 1, 1);
    c14 = mk(14, 2, 1, 9, 6, 1, 1, 3, 1, 1);
    tbl[0] = '{c: c1,                                 period: 60, de_n: 15, hs_n: 12, vs_n: 10, mx: 4, my: 2};
    tbl[1] = '{c: mk(10, 2, 1, 5, 6, 1, 1, 3, 0, 0), period: 60, de_n: 15, hs_n: 48, vs_n: 50, mx: 4, my: 2};
    tbl[2] = '{c: c12,                                period: 72, de_n: 21, hs_n: 12, vs_n: 12, mx: 6, my: 2};
    tbl[3] = '{c: mk(10, 0, 1, 5, 6, 1, 1, 0, 1, 1), period: 60, de_n: 0,  hs_n: 0,  vs_n: 10, mx: 0, my: 0};
    tbl[4] = '{c: mk(8, 1, 2, 4, 5, 2, 1, 2, 1, 1),  period: 40, de_n: 8,  hs_n: 5,  vs_n: 16, mx: 3, my: 1};

    bus.I_en = 0; bus.I_cfg_load = 0;
    set_cfg(c1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      do_reset(tbl[i].c);
      chk("rst_de", 64'(bus.O_de), 64'(0));
      chk("rst_hbvb", 64'({bus.O_hb, bus.O_vb}), 64'(2'b11));
      chk("rst_hsvs", 64'({bus.O_hs, bus.O_vs}), 64'({!tbl[i].c.hp, !tbl[i].c.vp}));
      chk("rst_busy", 64'(bus.O_cfg_busy), 64'(0));
      measure(p, dn, hn, vn, mx, my);
      chk("tbl_period", 64'(p), 64'(tbl[i].period));
      chk("tbl_de", 64'(dn), 64'(tbl[i].de_n));
      chk("tbl_hs", 64'(hn), 64'(tbl[i].hs_n));
      chk("tbl_vs", 64'(vn), 64'(tbl[i].vs_n));
      chk("tbl_maxxy", 64'({16'(mx), 16'(my)}), 64'({16'(tbl[i].mx), 16'(tbl[i].my)}));
    end

    // Mid-frame reload: busy until boundary, next frame uses 12-clock lines.
    do_reset(c1);
    repeat (20) step();
    set_cfg(c12); bus.I_cfg_load = 1; step(); bus.I_cfg_load = 0; set_cfg(c1);
    chk("midload_busy", 64'(bus.O_cfg_busy), 64'(1));
    measure(p, dn, hn, vn, mx, my);
    chk("midload_period", 64'(p), 64'(72));
    chk("midload_de", 64'(dn), 64'(21));
    chk("midload_busy_after", 64'(bus.O_cfg_busy), 64'(0));

    // Load on the exact frame-end cycle: applied directly, busy never rises.
    do_reset(c1);
    guard = 0;
    while (m_pos != 59 && guard < 200) begin step(); guard++; end
    chk("fe_reach", 64'(m_pos), 64'(59));
    set_cfg(c12); bus.I_cfg_load = 1; step(); bus.I_cfg_load = 0; set_cfg(c1);
    seen_busy = bus.O_cfg_busy;
    for (int i = 0; i < 10; i++) begin step(); seen_busy |= bus.O_cfg_busy; end
    chk("fe_nobusy", 64'(seen_busy), 64'(0));
    measure(p, dn, hn, vn, mx, my);
    chk("fe_period", 64'(p), 64'(72));

    // Two mid-frame loads: the second one wins.
    do_reset(c1);
    repeat (10) step();
    set_cfg(c14); bus.I_cfg_load = 1; step(); bus.I_cfg_load = 0;
    repeat (5) step();
    set_cfg(c12); bus.I_cfg_load = 1; step(); bus.I_cfg_load = 0; set_cfg(c1);
    chk("dbl_busy", 64'(bus.O_cfg_busy), 64'(1));
    measure(p, dn, hn, vn, mx, my);
    chk("dbl_period", 64'(p), 64'(72));
    chk("dbl_de", 64'(dn), 64'(21));

    // Stall mid-line: outputs hold, then the sequence resumes.
    do_reset(c1);
    repeat (24) step();
    snap = exp_vec();
    bus.I_en = 0;
    for (int i = 0; i < 5; i++) begin step(); chk("stall_hold", 64'(dut_vec()), 64'(snap)); end
    bus.I_en = 1;
    measure(p, dn, hn, vn, mx, my);
    chk("stall_period", 64'(p), 64'(60));
    chk("stall_de", 64'(dn), 64'(15));

    // One-cycle reset mid-frame.
    repeat (33) step();
    rst = 1; step(); rst = 0;
    chk("mrst_vals", 64'({bus.O_de, bus.O_hb, bus.O_vb, bus.O_hs, bus.O_vs, bus.O_sof, bus.O_sol}),
        64'(7'b0110000));
    chk("mrst_xy", 64'({bus.O_x, bus.O_y}), 64'(0));
    for (int i = 0; i < PIPE - 1; i++) begin step(); chk("mrst_nosof", 64'(bus.O_sof), 64'(0)); end
    step();
    chk("mrst_sof", 64'(bus.O_sof), 64'(1));

    // Random stimulus against the reference model.
    do_reset(rand_cfg());
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(399, 0) == 0);
      bus.I_cfg_load = ($urandom_range(49, 0) == 0);
      if (rst || bus.I_cfg_load) set_cfg(rand_cfg());
      bus.I_en = ($urandom_range(5, 0) != 0);
      step();
    end
    rst = 0; bus.I_cfg_load = 0; bus.I_en = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
